// File: rtl/vend_ctrl.sv
// Vending controller: credit register, 4-entry price table, dispense and change handshakes.
// Optional inactivity refund is enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl #(
  parameter int CREDIT_W    = 4,
  parameter int MAX_CREDIT  = 10,
  parameter int PRICE0      = 4,
  parameter int PRICE1      = 3,
  parameter int PRICE2      = 5,
  parameter int PRICE3      = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          coin,
  output logic                coin_rej,
  input  logic                sel_vld,
  input  logic [1:0]          sel_id,
  output logic                sel_rej,
  input  logic                cancel,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  localparam logic [CREDIT_W:0]   MAX_C = MAX_CREDIT[CREDIT_W:0];
  localparam logic [CREDIT_W-1:0] P0    = PRICE0[CREDIT_W-1:0];
  localparam logic [CREDIT_W-1:0] P1    = PRICE1[CREDIT_W-1:0];
  localparam logic [CREDIT_W-1:0] P2    = PRICE2[CREDIT_W-1:0];
  localparam logic [CREDIT_W-1:0] P3    = PRICE3[CREDIT_W-1:0];

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_n, coin_val, price;
  logic [CREDIT_W:0]   coin_sum;
  logic [1:0]          disp_id_n;
  logic                coin_rej_n, sel_rej_n, coin_fits, timeout;

  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = CREDIT_W'(1);
      2'b10:   coin_val = CREDIT_W'(2);
      default: coin_val = '0;
    endcase
    case (sel_id)
      2'd0:    price = P0;
      2'd1:    price = P1;
      2'd2:    price = P2;
      default: price = P3;
    endcase
  end

  assign coin_sum  = {1'b0, credit} + {1'b0, coin_val};
  assign coin_fits = (coin_val != '0) && (coin_sum <= MAX_C);

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt;

  // Timeout fires on the last of TIMEOUT_CYC quiet CREDIT cycles; coins that would be rejected do not count as activity.
  assign timeout = (state == CREDIT) && (to_cnt == TO_LAST) && !sel_vld && !coin_fits;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      to_cnt <= '0;
    else if (state != CREDIT || coin_fits || sel_vld || timeout)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + TW'(1);
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    credit_n   = credit;
    disp_id_n  = disp_id;
    coin_rej_n = 1'b0;
    sel_rej_n  = 1'b0;
    case (state)
      IDLE, CREDIT: begin
        if ((cancel && state == CREDIT) || timeout) begin
          state_n    = CHANGE;
          coin_rej_n = (coin_val != '0);
        end else if (sel_vld && credit >= price) begin
          state_n    = DISPENSE;
          credit_n   = credit - price;
          disp_id_n  = sel_id;
          coin_rej_n = (coin_val != '0);
        end else begin
          // A refused selection still lets a coincident coin through.
          sel_rej_n = sel_vld;
          if (coin_fits)
            credit_n = coin_sum[CREDIT_W-1:0];
          else
            coin_rej_n = (coin_val != '0);
          state_n = (credit_n == '0) ? IDLE : CREDIT;
        end
      end
      DISPENSE: begin
        coin_rej_n = (coin_val != '0);
        if (disp_ack)
          state_n = (credit != '0) ? CHANGE : IDLE;
      end
      default: begin
        coin_rej_n = (coin_val != '0);
        if (chg_req && chg_ack) begin
          credit_n = credit - CREDIT_W'(1);
          if (credit_n == '0)
            state_n = IDLE;
        end
      end
    endcase
  end

  // Every output is registered from next-state values so handshakes and busy line up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      credit   <= '0;
      disp_id  <= '0;
      disp_req <= 1'b0;
      chg_req  <= 1'b0;
      busy     <= 1'b0;
      coin_rej <= 1'b0;
      sel_rej  <= 1'b0;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      disp_id  <= disp_id_n;
      disp_req <= (state_n == DISPENSE);
      chg_req  <= (state_n == CHANGE) && (credit_n != '0);
      busy     <= (state_n == DISPENSE) || (state_n == CHANGE);
      coin_rej <= coin_rej_n;
      sel_rej  <= sel_rej_n;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed testbench for vend_ctrl with hand-computed expectations.
// Define VEND_TIMEOUT_EN for both files to exercise the inactivity refund.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_vld = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       coin_rej, sel_rej, disp_req, chg_req, busy;
  logic [1:0] disp_id;
  logic [3:0] credit;

  int vectors = 0;
  int miscompares = 0;

  vend_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn), .coin(coin), .coin_rej(coin_rej),
    .sel_vld(sel_vld), .sel_id(sel_id), .sel_rej(sel_rej), .cancel(cancel),
    .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_ack(chg_ack), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs; all inputs return to idle afterwards.
  task automatic applyStimulus(input logic [1:0] c, input logic sv, input logic [1:0] sid,
                               input logic can, input logic dack, input logic cack);
    coin = c; sel_vld = sv; sel_id = sid; cancel = can; disp_ack = dack; chg_ack = cack;
    tick();
    coin = 2'b00; sel_vld = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic drainChange(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(2'b00, 0, 0, 0, 0, 1);
      checkOutput("chg_credit", credit, n - 1 - k);
      checkOutput("chg_req_step", chg_req, (n - 1 - k) != 0);
    end
    checkOutput("chg_done_busy", busy, 0);
  endtask

  initial begin
    #12;
    checkOutput("rst_credit", credit, 0);
    checkOutput("rst_disp_req", disp_req, 0);
    checkOutput("rst_chg_req", chg_req, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_coin_rej", coin_rej, 0);
    checkOutput("rst_sel_rej", sel_rej, 0);
    rstn = 1'b1;

    // Exact-price purchase, no change due
    for (int i = 0; i < 4; i++) applyStimulus(2'b01, 0, 0, 0, 0, 0);
    checkOutput("t1_credit", credit, 4);
    applyStimulus(2'b00, 1, 2'd0, 0, 0, 0);
    checkOutput("t1_disp_req", disp_req, 1);
    checkOutput("t1_disp_id", disp_id, 0);
    checkOutput("t1_credit_after", credit, 0);
    checkOutput("t1_busy", busy, 1);
    applyStimulus(2'b00, 0, 0, 0, 1, 0);
    checkOutput("t1_disp_req_drop", disp_req, 0);
    checkOutput("t1_chg_req", chg_req, 0);
    checkOutput("t1_busy_idle", busy, 0);

    // Purchase with three coins of change
    for (int i = 0; i < 3; i++) applyStimulus(2'b10, 0, 0, 0, 0, 0);
    checkOutput("t2_credit", credit, 6);
    applyStimulus(2'b00, 1, 2'd1, 0, 0, 0);
    checkOutput("t2_disp_id", disp_id, 1);
    checkOutput("t2_credit_after", credit, 3);
    applyStimulus(2'b00, 0, 0, 0, 1, 0);
    checkOutput("t2_chg_req", chg_req, 1);
    checkOutput("t2_disp_req", disp_req, 0);
    checkOutput("t2_busy", busy, 1);
    drainChange(3);

    // Ignored coin code, refused selections, cancel refund
    applyStimulus(2'b11, 0, 0, 0, 0, 0);
    checkOutput("t3_coin11_rej", coin_rej, 0);
    checkOutput("t3_coin11_credit", credit, 0);
    applyStimulus(2'b10, 1, 2'd0, 0, 0, 0);
    checkOutput("t3_refuse_sel_rej", sel_rej, 1);
    checkOutput("t3_refuse_coin_credited", credit, 2);
    checkOutput("t3_refuse_coin_rej", coin_rej, 0);
    applyStimulus(2'b00, 1, 2'd3, 0, 0, 0);
    checkOutput("t3_sel_rej", sel_rej, 1);
    checkOutput("t3_credit_kept", credit, 2);
    checkOutput("t3_no_disp", disp_req, 0);
    applyStimulus(2'b00, 0, 0, 0, 0, 0);
    checkOutput("t3_sel_rej_pulse", sel_rej, 0);
    applyStimulus(2'b00, 0, 0, 1, 0, 0);
    checkOutput("t3_cancel_chg_req", chg_req, 1);
    checkOutput("t3_cancel_credit", credit, 2);
    drainChange(2);

    // Credit ceiling, coincident coin and selection, coin during dispense
    for (int i = 0; i < 5; i++) applyStimulus(2'b10, 0, 0, 0, 0, 0);
    checkOutput("t4_credit_max", credit, 10);
    applyStimulus(2'b01, 0, 0, 0, 0, 0);
    checkOutput("t4_over_rej", coin_rej, 1);
    checkOutput("t4_over_credit", credit, 10);
    applyStimulus(2'b01, 1, 2'd2, 0, 0, 0);
    checkOutput("t4_both_disp_req", disp_req, 1);
    checkOutput("t4_both_disp_id", disp_id, 2);
    checkOutput("t4_both_credit", credit, 5);
    checkOutput("t4_both_coin_rej", coin_rej, 1);
    applyStimulus(2'b10, 0, 0, 0, 0, 0);
    checkOutput("t4_disp_coin_rej", coin_rej, 1);
    checkOutput("t4_disp_credit", credit, 5);
    checkOutput("t4_disp_req_held", disp_req, 1);
    applyStimulus(2'b00, 0, 0, 0, 1, 0);
    checkOutput("t4_change_req", chg_req, 1);

    // Stalled hopper, then asynchronous reset mid-change
    for (int i = 0; i < 5; i++) applyStimulus(2'b00, 0, 0, 0, 0, 0);
    checkOutput("t5_stall_chg_req", chg_req, 1);
    checkOutput("t5_stall_credit", credit, 5);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t5_async_chg_req", chg_req, 0);
    checkOutput("t5_async_busy", busy, 0);
    checkOutput("t5_async_credit", credit, 0);
    #2 rstn = 1'b1;

    // Inactivity behaviour with credit 3
    applyStimulus(2'b10, 0, 0, 0, 0, 0);
    applyStimulus(2'b01, 0, 0, 0, 0, 0);
    checkOutput("t6_credit", credit, 3);
`ifdef VEND_TIMEOUT_EN
    for (int i = 0; i < 15; i++) applyStimulus(2'b00, 0, 0, 0, 0, 0);
    checkOutput("t6_before_timeout", chg_req, 0);
    checkOutput("t6_before_credit", credit, 3);
    applyStimulus(2'b00, 0, 0, 0, 0, 0);
    checkOutput("t6_timeout_chg_req", chg_req, 1);
    checkOutput("t6_timeout_busy", busy, 1);
    drainChange(3);
`else
    for (int i = 0; i < 100; i++) applyStimulus(2'b00, 0, 0, 0, 0, 0);
    checkOutput("t6_held_credit", credit, 3);
    checkOutput("t6_held_busy", busy, 0);
    checkOutput("t6_held_chg_req", chg_req, 0);
    applyStimulus(2'b00, 0, 0, 1, 0, 0);
    drainChange(3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
